// File: rtl/layer_load_sequencer.sv
// Host-side loader for the partitioned multi-layer buffer: takes a load command,
// streams beats into registered buffer writes, checks length/bounds, tracks loaded layers.
module layer_load_sequencer #(
    parameter int NUM_LAYERS = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    localparam int LID_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int LEN_W = ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LID_W-1:0]      cmd_layer,
    input  logic [ADDR_WIDTH-1:0] cmd_offset,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  wr_en,
    output logic [LID_W-1:0]      wr_layer,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  done,
    output logic [1:0]            err_code,
    output logic                  busy,
    input  logic                  inval_en,
    input  logic [LID_W-1:0]      inval_layer,
    output logic [NUM_LAYERS-1:0] layer_loaded
);

    localparam int LAYER_WORDS = 2 ** (ADDR_WIDTH - 3);
    // Wider than both operands so offset+len can never wrap.
    localparam int SUM_W = ADDR_WIDTH + 2;

    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_BOUNDS = 2'd1;
    localparam logic [1:0] ERR_SHORT  = 2'd2;
    localparam logic [1:0] ERR_LONG   = 2'd3;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESP} state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             err_pend_reg, err_next;
    logic [1:0]             err_code_reg;
    logic [LID_W-1:0]       layer_reg;
    logic [ADDR_WIDTH-1:0]  addr_ptr_reg;
    logic [LEN_W-1:0]       remaining_reg;
    logic                   wr_en_reg;
    logic [LID_W-1:0]       wr_layer_reg;
    logic [ADDR_WIDTH-1:0]  wr_addr_reg;
    logic [DATA_WIDTH-1:0]  wr_data_reg;
    logic [NUM_LAYERS-1:0]  loaded_reg, loaded_next;

    logic                   cmd_accept;
    logic                   stream_beat;
    logic                   cmd_bad;
    logic [SUM_W-1:0]       end_sum;

    assign cmd_ready   = (state_reg == IDLE);
    assign s_ready     = (state_reg == STREAM) || (state_reg == DRAIN);
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == RESP);
    assign cmd_accept  = cmd_valid && cmd_ready;
    assign stream_beat = s_valid && (state_reg == STREAM);

    assign end_sum = SUM_W'(cmd_offset) + SUM_W'(cmd_len);
    assign cmd_bad = (cmd_len == '0) || (int'(cmd_layer) >= NUM_LAYERS)
                   || (end_sum > SUM_W'(LAYER_WORDS));

    always_comb begin
        state_next = state_reg;
        err_next   = err_pend_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_accept) begin
                    state_next = cmd_bad ? DRAIN : STREAM;
                    err_next   = cmd_bad ? ERR_BOUNDS : ERR_OK;
                end
            end
            STREAM: begin
                if (s_valid) begin
                    if (remaining_reg == LEN_W'(1)) begin
                        state_next = s_last ? RESP : DRAIN;
                        err_next   = s_last ? ERR_OK : ERR_LONG;
                    end else if (s_last) begin
                        state_next = RESP;
                        err_next   = ERR_SHORT;
                    end
                end
            end
            DRAIN: begin
                if (s_valid && s_last) begin
                    state_next = RESP;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Invalidate and command-accept clears take priority over the RESP set.
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_loaded
        always_comb begin
            loaded_next[gi] = loaded_reg[gi];
            if ((inval_en && inval_layer == LID_W'(gi)) ||
                (cmd_accept && cmd_layer == LID_W'(gi))) begin
                loaded_next[gi] = 1'b0;
            end else if (state_reg == RESP && err_pend_reg == ERR_OK &&
                         layer_reg == LID_W'(gi)) begin
                loaded_next[gi] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            err_pend_reg  <= ERR_OK;
            err_code_reg  <= ERR_OK;
            layer_reg     <= '0;
            addr_ptr_reg  <= '0;
            remaining_reg <= '0;
            wr_en_reg     <= 1'b0;
            wr_layer_reg  <= '0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            loaded_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            err_pend_reg <= err_next;
            loaded_reg   <= loaded_next;
            wr_en_reg    <= stream_beat;
            if (cmd_accept) begin
                layer_reg     <= cmd_layer;
                addr_ptr_reg  <= cmd_offset;
                remaining_reg <= cmd_len;
            end
            if (stream_beat) begin
                wr_layer_reg  <= layer_reg;
                wr_addr_reg   <= addr_ptr_reg;
                wr_data_reg   <= s_data;
                addr_ptr_reg  <= addr_ptr_reg + ADDR_WIDTH'(1);
                remaining_reg <= remaining_reg - LEN_W'(1);
            end
            // err_code only changes as done rises, so it holds between completions.
            if (state_next == RESP) begin
                err_code_reg <= err_next;
            end
        end
    end

    assign wr_en        = wr_en_reg;
    assign wr_layer     = wr_layer_reg;
    assign wr_addr      = wr_addr_reg;
    assign wr_data      = wr_data_reg;
    assign err_code     = err_code_reg;
    assign layer_loaded = loaded_reg;

endmodule
